sram32x8_dp_arbiter: RTL and testbench

//  Shares both ports of the wrap_saed32_32x8 dual-port SRAM among NREQ requesters.

---
 rtl/sram32x8_arb_pkg.sv | 31 +++
 rtl/sram32x8_arb_rr_pick.sv | 33 +++
 rtl/sram32x8_dp_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram32x8_dp_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram32x8_arb_pkg.sv
// Shared constants, FSM state type and requester-slice helpers for the dual-port SRAM arbiter.
package sram32x8_arb_pkg;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned DEPTH   = 32;
    localparam int unsigned HALF    = 16;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    typedef logic [MAX_REQ*ADDR_W-1:0] avec_t;
    typedef logic [MAX_REQ*DATA_W-1:0] dvec_t;

    function automatic logic [ADDR_W-1:0] get_a(input avec_t v, input int unsigned i);
        return v[i*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] get_d(input dvec_t v, input int unsigned i);
        return v[i*DATA_W +: DATA_W];
    endfunction

    function automatic dvec_t put_d(input dvec_t v, input int unsigned i,
                                    input logic [DATA_W-1:0] d);
        dvec_t r;
        r = v;
        r[i*DATA_W +: DATA_W] = d;
        return r;
    endfunction

endpackage

// File: rtl/sram32x8_arb_rr_pick.sv
// Cyclic priority picker: first set request bit at or after ptr, as one-hot and index.
module sram32x8_arb_rr_pick
    import sram32x8_arb_pkg::*;
#(
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int unsigned j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sram32x8_dp_arbiter.sv
// Round-robin sharing of both wrapper SRAM ports among NREQ requesters, with post-reset clear.
// Optional same-address hazard guard: define SRAM32X8_ARB_COLLISION_GUARD_EN.
module sram32x8_dp_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    input  logic [NREQ*DATA_W-1:0] req_wem,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [NREQ*DATA_W-1:0] rsp_rdata,
    output logic                   init_done,
    output logic [ADDR_W-1:0]      A0,
    output logic [ADDR_W-1:0]      A1,
    output logic [DATA_W-1:0]      D0,
    output logic [DATA_W-1:0]      D1,
    output logic [DATA_W-1:0]      WEM0,
    output logic [DATA_W-1:0]      WEM1,
    output logic                   WE0,
    output logic                   WE1,
    output logic                   CE0,
    output logic                   CE1,
    input  logic [DATA_W-1:0]      Q0,
    input  logic [DATA_W-1:0]      Q1
);
    import sram32x8_arb_pkg::*;

    localparam int unsigned IDX_W = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(HALF);

    state_e             state;
    logic [CNT_W-1:0]   init_cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [NREQ-1:0]    rsp_port;

    logic [NREQ-1:0]    req0_vec, req1_vec, gnt0_oh, gnt1_oh, rsp_nxt;
    logic [IDX_W-1:0]   g0, g1, last_g;
    logic               f0, f1, use1, clash, we0, we1;
    logic [ADDR_W-1:0]  addr0, addr1;

    assign req0_vec = req_valid & {NREQ{state == ST_RUN}};
    assign req1_vec = req0_vec & ~gnt0_oh;

    sram32x8_arb_rr_pick #(.NREQ(NREQ)) u_pick0 (
        .req(req0_vec), .ptr(rr_ptr), .gnt(gnt0_oh), .idx(g0), .found(f0)
    );

    // Searching from rr_ptr with g0 masked yields the next valid requester after g0.
    sram32x8_arb_rr_pick #(.NREQ(NREQ)) u_pick1 (
        .req(req1_vec), .ptr(rr_ptr), .gnt(gnt1_oh), .idx(g1), .found(f1)
    );

    assign addr0 = get_a(avec_t'(req_addr), 32'(g0));
    assign addr1 = get_a(avec_t'(req_addr), 32'(g1));
    assign we0   = req_we[g0];
    assign we1   = req_we[g1];

`ifdef SRAM32X8_ARB_COLLISION_GUARD_EN
    assign clash = (addr0 == addr1) && (we0 || we1);
`else
    assign clash = 1'b0;
`endif

    assign use1    = f1 && !clash;
    assign last_g  = use1 ? g1 : g0;
    assign rsp_nxt = ((f0 && !we0) ? gnt0_oh : '0) | ((use1 && !we1) ? gnt1_oh : '0);

    // Wrapper strobes held off while reset is asserted; clear pattern in INIT, grants in RUN.
    always_comb begin
        req_ready = '0;
        A0 = '0;  D0 = '0;  WEM0 = '0;  WE0 = 1'b0;  CE0 = 1'b0;
        A1 = '0;  D1 = '0;  WEM1 = '0;  WE1 = 1'b0;  CE1 = 1'b0;
        if (RSTN) begin
            if (state == ST_INIT) begin
                CE0  = 1'b1;  WE0 = 1'b1;  WEM0 = '1;
                CE1  = 1'b1;  WE1 = 1'b1;  WEM1 = '1;
                A0   = ADDR_W'(init_cnt);
                A1   = ADDR_W'(init_cnt) + ADDR_W'(HALF);
            end else begin
                if (f0) begin
                    req_ready = gnt0_oh;
                    CE0  = 1'b1;
                    WE0  = we0;
                    A0   = addr0;
                    D0   = get_d(dvec_t'(req_wdata), 32'(g0));
                    WEM0 = get_d(dvec_t'(req_wem), 32'(g0));
                end
                if (use1) begin
                    req_ready = req_ready | gnt1_oh;
                    CE1  = 1'b1;
                    WE1  = we1;
                    A1   = addr1;
                    D1   = get_d(dvec_t'(req_wdata), 32'(g1));
                    WEM1 = get_d(dvec_t'(req_wem), 32'(g1));
                end
            end
        end
    end

    // Q arrives the cycle after the access, alongside the registered rsp_valid.
    dvec_t rd;
    always_comb begin
        rd = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (rsp_valid[i]) rd = put_d(rd, i, rsp_port[i] ? Q1 : Q0);
        end
        rsp_rdata = rd[NREQ*DATA_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            rr_ptr    <= '0;
            init_done <= 1'b0;
            rsp_valid <= '0;
            rsp_port  <= '0;
        end else begin
            rsp_valid <= '0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + CNT_W'(1);
                    if (init_cnt == CNT_W'(HALF - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    rsp_valid <= rsp_nxt;
                    rsp_port  <= use1 ? gnt1_oh : '0;
                    if (f0) begin
                        rr_ptr <= (last_g == IDX_W'(NREQ - 1)) ? '0 : last_g + IDX_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram32x8_dp_arbiter.sv
// Bench for sram32x8_dp_arbiter: behavioural SRAM, reference memory and cyclic-grant model.
module tb_sram32x8_dp_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 8;

    logic CLK = 1'b0;
    logic RSTN = 1'b0;
    logic [NREQ-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata, req_wem, rsp_rdata;
    logic               init_done;
    logic [AW-1:0]      A0, A1;
    logic [DW-1:0]      D0, D1, WEM0, WEM1, Q0, Q1;
    logic               WE0, WE1, CE0, CE1;

    logic [NREQ-1:0] v, w;
    logic [AW-1:0]   a [NREQ];
    logic [DW-1:0]   d [NREQ];
    logic [DW-1:0]   m [NREQ];

    int errors = 0;
    int checks = 0;
    int rr = 0;
    logic [DW-1:0]   ref_mem [32];
    logic [NREQ-1:0] last_rdy;

    always #5 CLK = ~CLK;

    sram32x8_dp_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wem(req_wem),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WEM0(WEM0), .WEM1(WEM1),
        .WE0(WE0), .WE1(WE1), .CE0(CE0), .CE1(CE1), .Q0(Q0), .Q1(Q1)
    );

    always_comb begin
        req_valid = v;
        req_we    = w;
        req_addr  = '0;
        req_wdata = '0;
        req_wem   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = a[i];
            req_wdata[i*DW +: DW] = d[i];
            req_wem[i*DW +: DW]   = m[i];
        end
    end

    // Dual-port SRAM: read data appears the cycle after the enabled edge; starts with garbage.
    logic [DW-1:0] mem [32];
    bit pre_done = 1'b0;
    always @(posedge CLK) begin
        if (!pre_done) begin
            for (int k = 0; k < 32; k++) mem[k] = 8'($urandom_range(1, 255));
            pre_done = 1'b1;
        end
        if (CE0 && !WE0) Q0 <= mem[A0];
        if (CE1 && !WE1) Q1 <= mem[A1];
        if (CE0 && WE0) mem[A0] = (mem[A0] & ~WEM0) | (D0 & WEM0);
        if (CE1 && WE1) mem[A1] = (mem[A1] & ~WEM1) | (D1 & WEM1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One RUN cycle: predict grants from the pointer, apply to the reference memory, check responses.
    task automatic step();
        int g [$];
        logic [NREQ-1:0]    exp_rdy, exp_rv;
        logic [NREQ*DW-1:0] exp_rd;
        #1;
        for (int k = 0; k < NREQ; k++) begin
            int j = (rr + k) % NREQ;
            if (v[j] && g.size() < 2) g.push_back(j);
        end
`ifdef SRAM32X8_ARB_COLLISION_GUARD_EN
        if (g.size() == 2 && a[g[0]] == a[g[1]] && (w[g[0]] || w[g[1]])) void'(g.pop_back());
`endif
        exp_rdy = '0;
        exp_rv  = '0;
        exp_rd  = '0;
        foreach (g[n]) exp_rdy[g[n]] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("CE0", 64'(CE0), 64'(g.size() > 0));
        chk("CE1", 64'(CE1), 64'(g.size() > 1));
        if (g.size() > 0) chk("A0", 64'(A0), 64'(a[g[0]]));
        if (g.size() > 1) chk("A1", 64'(A1), 64'(a[g[1]]));
        last_rdy = req_ready;
        foreach (g[n]) if (!w[g[n]]) begin
            exp_rv[g[n]] = 1'b1;
            exp_rd[g[n]*DW +: DW] = ref_mem[a[g[n]]];
        end
        foreach (g[n]) if (w[g[n]])
            ref_mem[a[g[n]]] = (ref_mem[a[g[n]]] & ~m[g[n]]) | (d[g[n]] & m[g[n]]);
        if (g.size() > 0) rr = (g[g.size()-1] + 1) % NREQ;
        @(posedge CLK);
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        foreach (g[n]) v[g[n]] = 1'b0;
    endtask

    initial begin
        v = '0;
        w = '0;
        for (int i = 0; i < NREQ; i++) begin
            a[i] = '0; d[i] = '0; m[i] = '0;
        end
        for (int k = 0; k < 32; k++) ref_mem[k] = '0;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ce", 64'({CE0, CE1, WE0, WE1}), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp", 64'({rsp_valid, rsp_rdata}), 64'(0));
        chk("rst_init_done", 64'(init_done), 64'(0));

        // Clear sequence after reset release
        RSTN = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk("init_strobes", 64'({CE0, CE1, WE0, WE1}), 64'hF);
            chk("init_A0", 64'(A0), 64'(c));
            chk("init_A1", 64'(A1), 64'(c + 16));
            chk("init_dwem", 64'({D0, D1, WEM0, WEM1}), 64'h0000FFFF);
            chk("init_busy", 64'({init_done, req_ready}), 64'(0));
            @(posedge CLK);
        end
        #1;
        chk("init_done", 64'(init_done), 64'(1));
        for (int k = 0; k < 32; k++) chk("mem_clear", 64'(mem[k]), 64'(0));

        // Write then read back through the same requester
        v[0] = 1'b1; w[0] = 1'b1; a[0] = 5'd3; d[0] = 8'hA5; m[0] = 8'hFF;
        step();
        v[0] = 1'b1; w[0] = 1'b0; a[0] = 5'd3;
        step();
        chk("t2_rsp_valid0", 64'(rsp_valid[0]), 64'(1));
        chk("t2_rdata0", 64'(rsp_rdata[7:0]), 64'hA5);

        // Same-address writes from requesters 1 and 2
        v[1] = 1'b1; w[1] = 1'b1; a[1] = 5'd7; d[1] = 8'h3C; m[1] = 8'hFF;
        v[2] = 1'b1; w[2] = 1'b1; a[2] = 5'd7; d[2] = 8'hC3; m[2] = 8'hFF;
        step();
`ifdef SRAM32X8_ARB_COLLISION_GUARD_EN
        chk("t4_first", 64'(last_rdy), 64'h2);
        step();
        chk("t4_second", 64'(last_rdy), 64'h4);
        v[3] = 1'b1; w[3] = 1'b0; a[3] = 5'd7;
        step();
        chk("t4_word", 64'(rsp_rdata[31:24]), 64'hC3);
`else
        chk("t4_both", 64'(last_rdy), 64'h6);
        v[3] = 1'b1; w[3] = 1'b1; a[3] = 5'd7; d[3] = 8'h5A; m[3] = 8'hFF;
        step();
`endif

        // All four requesters reading continuously
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                v[i] = 1'b1; w[i] = 1'b0; a[i] = 5'(i*8 + 1);
            end
            step();
            chk("t3_grant", 64'(last_rdy), (r % 2 == 0) ? 64'h3 : 64'hC);
        end
        step();
        chk("t3_drain", 64'(last_rdy), 64'hC);

        // Reset while a read is in flight; a request waits out the clear
        v[1] = 1'b1; w[1] = 1'b0; a[1] = 5'd3;
        #1;
        chk("t5_grant", 64'(req_ready), 64'h2);
        RSTN = 1'b0;
        v[1] = 1'b0;
        @(posedge CLK);
        #1;
        chk("t5_rsp_dropped", 64'(rsp_valid), 64'(0));
        chk("t5_ce_off", 64'({CE0, CE1}), 64'(0));
        v[2] = 1'b1; w[2] = 1'b0; a[2] = 5'd3;
        rr = 0;
        for (int k = 0; k < 32; k++) ref_mem[k] = '0;
        RSTN = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            chk("t5_reinit_A0", 64'({CE0, A0}), 64'({1'b1, 5'(c)}));
            chk("t6_held", 64'({init_done, req_ready}), 64'(0));
            @(posedge CLK);
        end
        #1;
        chk("t5_init_done", 64'(init_done), 64'(1));
        step();
        chk("t6_first_run", 64'(last_rdy), 64'h4);
        chk("t5_mem_zero", 64'(rsp_rdata[23:16]), 64'(0));

        // Random traffic, each requester confined to its own 8-word region
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    w[i] = 1'($urandom_range(0, 1));
                    a[i] = 5'(i*8 + int'($urandom_range(0, 7)));
                    d[i] = 8'($urandom);
                    m[i] = 8'($urandom);
                end
            end
            step();
        end
        for (int k = 0; k < 32; k++) chk("mem_final", 64'(mem[k]), 64'(ref_mem[k]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
